instruction_fetcher: RTL

Front-end producer for the decoder. Holds the PC, fetches 32-bit instruction words through a direct-mapped instruction cache backed by the memory controller, and generates the sign-extended immediate. Issues one instruction per cycle as a single-cycle ins_flag pulse. Static prediction: branches not-taken, JAL followed immediately, JALR parks until the ROB redirects.

---
 rtl/instruction_fetcher_pkg.sv | 21 ++
 rtl/instruction_fetcher_imm_gen.sv | 32 +++
 rtl/instruction_fetcher.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetcher_pkg.sv
// Shared opcode heads and fetcher state encoding.
// Used by the fetcher and by imm_gen.
package instruction_fetcher_pkg;

  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE,
    MISS,
    JALR_WAIT
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetcher_imm_gen.sv
// imm_gen: sign-extended immediate of a 32-bit RV32I word.
// Purely combinational; also usable for target checks in the ROB.
module imm_gen
  import instruction_fetcher_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    unique case (word[6:0])
      OP_LOAD, OP_IMM, OP_JALR:
        imm = {{20{word[31]}}, word[31:20]};
      OP_STORE:
        imm = {{20{word[31]}}, word[31:25], word[11:7]};
      OP_B:
        imm = {{19{word[31]}}, word[31], word[7],
               word[30:25], word[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {word[31:12], 12'b0};
      OP_JAL:
        imm = {{11{word[31]}}, word[31], word[19:12],
               word[20], word[30:21], 1'b0};
      OP_REG:
        imm = '0;
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: PC, fetch, static prediction, issue to decoder.
// Define ICACHE_EN for the direct-mapped cache; otherwise every word is fetched.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int          ICACHE_LINES = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall,
  input  logic        jump_flag,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_ins,
  input  logic        mem_done,
  output logic [31:0] ins,
  output logic        ins_flag,
  output logic [31:0] ins_imm,
  output logic [31:0] ins_pc
);

  if ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_chk
    $error("ICACHE_LINES must be a power of 2");
  end

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:2]  miss_addr;
  logic         hit, issue, req_start, fill;
  logic [31:0]  hit_word, issue_word, imm;
  logic         is_jal, is_jalr;

`ifdef ICACHE_EN
  localparam int IW = $clog2(ICACHE_LINES);
  localparam int TW = 30 - IW;

  logic [ICACHE_LINES-1:0] valid;
  logic [TW-1:0]           tag_arr  [ICACHE_LINES];
  logic [31:0]             data_arr [ICACHE_LINES];
  logic [IW-1:0]           idx, fill_idx;

  assign idx      = pc[IW+1:2];
  assign fill_idx = miss_addr[IW+1:2];
  assign hit      = valid[idx] &&
                    (tag_arr[idx] == pc[31:IW+2]);
  assign hit_word = data_arr[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      valid <= '0;
    else if (rdy && fill)
      valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rdy && fill) begin
      tag_arr[fill_idx]  <= miss_addr[31:IW+2];
      data_arr[fill_idx] <= mem_ins;
    end
  end
`else
  // One-word buffer holds a fetched word that arrived under stall.
  logic        buf_valid;
  logic [31:0] buf_word;

  assign hit      = buf_valid;
  assign hit_word = buf_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_word  <= '0;
    end else if (rdy) begin
      if (jump_flag || issue)
        buf_valid <= 1'b0;
      else if (fill && pc[31:2] == miss_addr) begin
        buf_valid <= 1'b1;
        buf_word  <= mem_ins;
      end
    end
  end
`endif

  imm_gen u_imm (
    .word (issue_word),
    .imm  (imm)
  );

  assign is_jal  = issue_word[6:0] == OP_JAL;
  assign is_jalr = issue_word[6:0] == OP_JALR;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    issue      = 1'b0;
    issue_word = hit_word;
    req_start  = 1'b0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!jump_flag) begin
          if (hit) begin
            if (!stall)
              issue = 1'b1;
          end else begin
            req_start = 1'b1;
            state_n   = MISS;
          end
        end
      end
      MISS: begin
        if (mem_done) begin
          fill    = 1'b1;
          state_n = IDLE;
`ifndef ICACHE_EN
          // A redirect during the miss leaves pc off miss_addr.
          if (!jump_flag && !stall &&
              pc[31:2] == miss_addr) begin
            issue      = 1'b1;
            issue_word = mem_ins;
          end
`endif
        end
      end
      JALR_WAIT: ;
      default: state_n = IDLE;
    endcase
    if (issue) begin
      unique case (1'b1)
        is_jal:  pc_n = pc + imm;
        is_jalr: state_n = JALR_WAIT;
        default: pc_n = pc + 32'd4;
      endcase
    end
    if (jump_flag) begin
      pc_n = jump_pc;
      if (state != MISS || mem_done)
        state_n = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else if (rdy)
      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      miss_addr <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      ins       <= '0;
      ins_flag  <= 1'b0;
      ins_imm   <= '0;
      ins_pc    <= '0;
    end else if (rdy) begin
      pc       <= pc_n;
      ins_flag <= issue;
      if (issue) begin
        ins     <= issue_word;
        ins_imm <= imm;
        ins_pc  <= pc;
      end
      if (req_start) begin
        mem_req   <= 1'b1;
        mem_addr  <= pc;
        miss_addr <= pc[31:2];
      end else if (fill) begin
        mem_req <= 1'b0;
      end
    end
  end

endmodule
